// File: rtl/key_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: 2-FF sync, per-key debounce, press capture and IRQ.
// Optional build macro KEY_ANY_EDGE_EN: capture both press and release events.
module key_debounce_irq_ctrl #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] in_port,
  output logic                irq
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

  localparam logic [1:0]       ADDR_DATA    = 2'd0;
  localparam logic [1:0]       ADDR_IRQMASK = 2'd1;
  localparam logic [1:0]       ADDR_EDGECAP = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_deb;
  logic [NUM_KEYS-1:0] r_deb_d;
  logic [NUM_KEYS-1:0] r_mask;
  logic [NUM_KEYS-1:0] r_ecap;
  deb_state_t          r_state [NUM_KEYS];
  logic [CNT_W-1:0]    r_cnt   [NUM_KEYS];

  logic                w_wr;
  logic [NUM_KEYS-1:0] w_event;
  logic [NUM_KEYS-1:0] w_clr;
  logic [NUM_KEYS-1:0] w_mask_next;
  logic [NUM_KEYS-1:0] w_ecap_next;
  logic [31:0]         w_rd_mux;
  logic                w_unused_bits;

  // read strobe does not gate readdata; only the low writedata bits are register bits
  assign w_unused_bits = ^{read, writedata};

  // Keys idle high, so the synchroniser resets to "released".
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Entering COUNTING loads 1 because that cycle's differing sample already counts,
  // so the level flips on exactly the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: these per-key arrays are plain flops, not RAM, so they are reset explicitly.
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= ST_STABLE;
        r_cnt[k]   <= '0;
      end
      r_deb <= '1;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        case (r_state[k])
          ST_STABLE: begin
            if (r_sync2[k] != r_deb[k]) begin
              r_state[k] <= ST_COUNTING;
              r_cnt[k]   <= CNT_W'(1);
            end
          end
          ST_COUNTING: begin
            if (r_sync2[k] == r_deb[k]) begin
              r_state[k] <= ST_STABLE;
              r_cnt[k]   <= '0;
            end else if (r_cnt[k] == CNT_LAST) begin
              r_deb[k]   <= r_sync2[k];
              r_state[k] <= ST_STABLE;
              r_cnt[k]   <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
          end
          default: begin
            r_state[k] <= ST_STABLE;
            r_cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef KEY_ANY_EDGE_EN
  assign w_event = r_deb_d ^ r_deb;
`else
  assign w_event = r_deb_d & ~r_deb;
`endif

  assign w_wr        = chipselect & write;
  assign w_clr       = (w_wr && (address == ADDR_EDGECAP)) ? writedata[NUM_KEYS-1:0] : '0;
  assign w_mask_next = (w_wr && (address == ADDR_IRQMASK)) ? writedata[NUM_KEYS-1:0] : r_mask;
  // OR-ing the event after the clear makes a coincident set win.
  assign w_ecap_next = (r_ecap & ~w_clr) | w_event;

  always_comb begin
    // NOTE: default first so no path through the case leaves w_rd_mux unassigned (no latch).
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[NUM_KEYS-1:0] = r_deb;
      ADDR_IRQMASK: w_rd_mux[NUM_KEYS-1:0] = r_mask;
      ADDR_EDGECAP: w_rd_mux[NUM_KEYS-1:0] = r_ecap;
      default:      w_rd_mux = '0;
    endcase
  end

  // r_deb_d resets with r_deb so reset release never looks like a transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_deb_d  <= '1;
      r_mask   <= '0;
      r_ecap   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      r_deb_d  <= r_deb;
      r_mask   <= w_mask_next;
      r_ecap   <= w_ecap_next;
      irq      <= |(w_ecap_next & w_mask_next);
      readdata <= w_rd_mux;
    end
  end

endmodule
